cordic_rot: RTL and testbench

- Parametrised successor to the 8-bit angle-tracking CORDIC.
- Iterative rotation-mode CORDIC that runs full X/Y/Z datapaths and returns signed cosine and sine of an input binary angle over the full 0–360° range.
- One micro-rotation per clock, with a START/BUSY/DONE handshake.
- Feeds the DSP chain wherever a sin/cos pair is needed, such as NCO and mixer coefficient generation.

---
 rtl/cordic_rot.sv | 191 +++++++++++++++++++
 tb/tb_cordic_rot.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_rot.sv
// cordic_rot: iterative rotation-mode CORDIC, sin/cos of a binary angle.
// Optional CORDIC_ROUND_EN: round-half-up output scaling instead of truncation.
module cordic_rot #(
  parameter int WIDTH  = 16,
  parameter int ITER   = 14,
  parameter int X_INIT = 9949
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] ANGLE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] COS,
  output logic [WIDTH-1:0] SIN
);

  localparam int XW = WIDTH + 4;
  localparam int ZW = WIDTH + 1;
  localparam int IW = $clog2(ITER);

  localparam logic signed [XW-1:0] LIM = XW'(1) <<< (WIDTH - 2);
  localparam logic [WIDTH-1:0] LIM_P = WIDTH'(1) << (WIDTH - 2);
  localparam logic [WIDTH-1:0] LIM_N = ~LIM_P + WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROTATE,
    S_FINISH
  } state_t;

  // atan(2^-i) in turns * 2^WIDTH; series in 40-bit fixed point
  // normalised against pi/4 so i=0 lands exactly on 2^(WIDTH-3).
  function automatic logic [ZW-1:0] atan_f(input int i);
    longint acc;
    longint term;
    longint pi4;
    longint res;
    int     sh;
    acc = 0;
    pi4 = 64'sd863554413089;
    if (i == 0) begin
      res = longint'(1) << (WIDTH - 3);
    end else begin
      for (int k = 0; k < 24; k++) begin
        sh = 40 - i * (2 * k + 1);
        if (sh >= 0) begin
          term = (longint'(1) << sh) / longint'(2 * k + 1);
          acc  = (k % 2 == 1) ? acc - term : acc + term;
        end
      end
      res = (acc * (longint'(1) << (WIDTH - 3)) + pi4 / 2) / pi4;
    end
    return ZW'(res);
  endfunction

  // Saturate a scaled datapath value to +/-1.0 in output format.
  function automatic logic [WIDTH-1:0] clamp_f(input logic signed [XW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > LIM) r = LIM_P;
    else if (v < -LIM) r = LIM_N;
    else r = v[WIDTH-1:0];
    return r;
  endfunction

  logic [ZW-1:0] w_atan [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    assign w_atan[g] = atan_f(g);
  end

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_iter;
  logic signed [XW-1:0]  r_x;
  logic signed [XW-1:0]  r_y;
  logic signed [ZW-1:0]  r_z;
  logic                  r_neg;
  logic                  r_busy;
  logic                  r_done;
  logic [WIDTH-1:0]      r_cos;
  logic [WIDTH-1:0]      r_sin;

  logic                  w_fold;
  logic [WIDTH-1:0]      w_a;
  logic signed [ZW-1:0]  w_z0;
  logic                  w_pos;
  logic                  w_last;
  logic signed [ZW-1:0]  w_at;
  logic signed [XW-1:0]  w_xs;
  logic signed [XW-1:0]  w_ys;
  logic signed [XW-1:0]  w_xn;
  logic signed [XW-1:0]  w_yn;
  logic signed [ZW-1:0]  w_zn;
  logic signed [XW-1:0]  w_xr;
  logic signed [XW-1:0]  w_yr;
  logic signed [XW-1:0]  w_xf;
  logic signed [XW-1:0]  w_yf;

  // Quadrant fold and one micro-rotation step.
  always_comb begin
    w_fold = ANGLE[WIDTH-1] ^ ANGLE[WIDTH-2];
    w_a    = {ANGLE[WIDTH-1] ^ w_fold, ANGLE[WIDTH-2:0]};
    w_z0   = {w_a[WIDTH-1], w_a};
    w_pos  = ~r_z[ZW-1];
    w_last = (r_iter == IW'(ITER - 1));
    w_at   = '0;
    for (int k = 0; k < ITER; k++) begin
      if (r_iter == IW'(k)) w_at = w_atan[k];
    end
    w_xs = r_x >>> r_iter;
    w_ys = r_y >>> r_iter;
    w_xn = w_pos ? r_x - w_ys : r_x + w_ys;
    w_yn = w_pos ? r_y + w_xs : r_y - w_xs;
    w_zn = w_pos ? r_z - w_at : r_z + w_at;
`ifdef CORDIC_ROUND_EN
    w_xr = (r_x + XW'(2)) >>> 2;
    w_yr = (r_y + XW'(2)) >>> 2;
`else
    w_xr = r_x >>> 2;
    w_yr = r_y >>> 2;
`endif
    w_xf = r_neg ? -w_xr : w_xr;
    w_yf = r_neg ? -w_yr : w_yr;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (START) w_next = S_ROTATE;
      S_ROTATE: if (w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_iter <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_neg  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cos  <= '0;
      r_sin  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_x    <= XW'(X_INIT * 4);
            r_y    <= '0;
            r_z    <= w_z0;
            r_neg  <= w_fold;
            r_iter <= '0;
            r_busy <= 1'b1;
          end
        end
        S_ROTATE: begin
          r_x    <= w_xn;
          r_y    <= w_yn;
          r_z    <= w_zn;
          r_iter <= w_last ? '0 : r_iter + IW'(1);
        end
        S_FINISH: begin
          r_cos  <= clamp_f(w_xf);
          r_sin  <= clamp_f(w_yf);
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign COS  = r_cos;
  assign SIN  = r_sin;

endmodule

// File: tb/tb_cordic_rot.sv
// tb_cordic_rot: scoreboard bench for cordic_rot.
// Directed angles with hand-computed sin/cos, handshake and reset cases.
module tb_cordic_rot;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [15:0] ANGLE;
  logic        BUSY;
  logic        DONE;
  logic [15:0] COS;
  logic [15:0] SIN;

  always #5 CLK = ~CLK;

  cordic_rot dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .ANGLE (ANGLE),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .COS   (COS),
    .SIN   (SIN)
  );

  typedef struct {
    int          c;
    int          s;
    logic [15:0] a;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int req, input int tol);
    checks++;
    if (act - req > tol || req - act > tol) begin
      errors++;
      $display("FAIL %s actual %0d required %0d tol %0d", nm, act, req, tol);
    end
  endtask

  // Monitor: every DONE pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DONE) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual 1 required 0");
        end else begin
          e = q.pop_front();
          chk($sformatf("cos_%h", e.a), int'($signed(COS)), e.c, 5);
          chk($sformatf("sin_%h", e.a), int'($signed(SIN)), e.s, 5);
          chk("cos_range", int'($signed(COS)), 0, 16384);
          chk("sin_range", int'($signed(SIN)), 0, 16384);
        end
      end
    end
  end

  // Issue one request at the current negedge; returns at the DONE negedge.
  task automatic go(input logic [15:0] a, input int ec, input int es,
                    input int ign_at);
    int  c;
    int  busy_n;
    bit  seen;
    busy_n = 0;
    seen   = 1'b0;
    START  = 1'b1;
    ANGLE  = a;
    q.push_back('{ec, es, a});
    for (c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (BUSY) busy_n++;
      if (c == 1) begin
        START = 1'b0;
        ANGLE = 16'($urandom);
      end
      if (ign_at > 0 && c == ign_at) begin
        START = 1'b1;
        ANGLE = 16'h8000;
      end else if (ign_at > 0 && c == ign_at + 1) begin
        START = 1'b0;
      end
    end
    chk($sformatf("latency_%h", a), seen ? c : -1, 16, 0);
    chk($sformatf("busy_cycles_%h", a), busy_n, 15, 0);
  endtask

  logic [15:0] va [11];
  int          vc [11];
  int          vs [11];

  initial begin
    int nd;
    va = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hE000,
           16'h6000, 16'hA000, 16'hF000, 16'h5000, 16'h0800};
    vc = '{16384, 0, -16384, 0, 11585, 11585,
           -11585, -11585, 15137, -6270, 16069};
    vs = '{0, 16384, 0, -16384, 11585, -11585,
           11585, -11585, -6270, 15137, 3196};

    RESET = 1'b1;
    START = 1'b0;
    ANGLE = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0, 0);
    chk("rst_done", int'(DONE), 0, 0);
    chk("rst_cos", int'($signed(COS)), 0, 0);
    chk("rst_sin", int'($signed(SIN)), 0, 0);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 11; i++) begin
      go(va[i], vc[i], vs[i], 0);
      @(negedge CLK);
    end

    go(16'h1000, 15137, 6270, 3);
    @(negedge CLK);

    go(16'h2000, 11585, 11585, 0);
    go(16'h4000, 0, 16384, 0);
    @(negedge CLK);

    START = 1'b1;
    ANGLE = 16'h6000;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_busy", int'(BUSY), 0, 0);
    chk("abort_done", int'(DONE), 0, 0);
    chk("abort_cos", int'($signed(COS)), 0, 0);
    chk("abort_sin", int'($signed(SIN)), 0, 0);
    nd = 0;
    repeat (25) begin
      @(negedge CLK);
      if (DONE) nd++;
    end
    chk("abort_no_done", nd, 0, 0);

    RESET = 1'b1;
    START = 1'b1;
    ANGLE = 16'h4000;
    @(negedge CLK);
    RESET = 1'b0;
    START = 1'b0;
    chk("rst_start_busy", int'(BUSY), 0, 0);
    nd = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE) nd++;
    end
    chk("rst_start_no_done", nd, 0, 0);

    go(16'h5000, -6270, 15137, 0);
    repeat (3) @(negedge CLK);
    chk("queue_empty", q.size(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

endmodule
